// File: rtl/riscv_pkg.sv
// Shared integer-core types: register width, register count and address type.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
endpackage

// File: rtl/sb_counter.sv
// One pending-write counter: increments on issue, drops by 0..2 per cycle
// (writeback retire and execute cancel), clamps at both ends.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] eff
);
  localparam logic [CNT_W+1:0] MAXV = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W+1:0] up;
  logic [CNT_W+1:0] dec_w;
  logic [CNT_W+1:0] nxt;

  // net the events; never go below zero and never wrap past the top
  always_comb begin
    up    = {2'b00, cnt} + {{(CNT_W+1){1'b0}}, inc};
    dec_w = {{CNT_W{1'b0}}, dec};
    nxt   = (up < dec_w) ? '0 : up - dec_w;
    if (nxt > MAXV) nxt = MAXV;
    eff   = (cnt < dec_w[CNT_W-1:0] || dec_w > {2'b00, cnt}) ? '0
          : cnt - dec_w[CNT_W-1:0];
  end

  // counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= nxt[CNT_W-1:0];
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-side register file with writeback bypass and a per-register
// pending-write scoreboard that raises StallD on read-after-write hazards.
module regfile_scoreboard
  import riscv_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       A1D,
  input  logic [4:0]       A2D,
  input  logic             UsesRs1D,
  input  logic             UsesRs2D,
  output logic [XLEN-1:0]  RD1D,
  output logic [XLEN-1:0]  RD2D,
  input  logic             IssueD,
  input  logic             RegWriteD,
  input  logic [4:0]       RdD,
  input  logic             CancelE,
  input  logic             RegWriteE,
  input  logic [4:0]       RdE,
  input  logic             RegWriteW,
  input  logic [4:0]       RdW,
  input  logic [XLEN-1:0]  ResultW,
  output logic             StallD,
  output logic [NREGS-1:0] BusyMask
);
  xlen_t [NREGS-1:0]            rf;
  logic  [NREGS-1:0][CNT_W-1:0] cnt;
  logic  [NREGS-1:0][CNT_W-1:0] eff;
  logic  [NREGS-1:0]            inc;
  logic  [NREGS-1:0]            ret_w;
  logic  [NREGS-1:0]            can_e;
  logic  [NREGS-1:0]            eff_nz;
  logic  [NREGS-1:0]            cnt_max;

  // register storage; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rf <= '0;
    else if (RegWriteW && RdW != '0)  rf[RdW] <= ResultW;
  end

  // read ports: x0 reads zero, a same-cycle writeback is forwarded,
  // and the ports are held at zero while reset is asserted
  always_comb begin
    RD1D = '0;
    RD2D = '0;
    if (rst_n) begin
      if (A1D == '0)                        RD1D = '0;
      else if (RegWriteW && RdW == A1D)     RD1D = ResultW;
      else                                  RD1D = rf[A1D];
      if (A2D == '0)                        RD2D = '0;
      else if (RegWriteW && RdW == A2D)     RD2D = ResultW;
      else                                  RD2D = rf[A2D];
    end
  end

  // x0 never has a pending write
  assign cnt[0]     = '0;
  assign eff[0]     = '0;
  assign inc[0]     = 1'b0;
  assign ret_w[0]   = 1'b0;
  assign can_e[0]   = 1'b0;
  assign eff_nz[0]  = 1'b0;
  assign cnt_max[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_sb
    assign inc[i]   = IssueD && !StallD && RegWriteD && (RdD == reg_addr_t'(i));
    assign ret_w[i] = RegWriteW && (RdW == reg_addr_t'(i));
    assign can_e[i] = CancelE && RegWriteE && (RdE == reg_addr_t'(i));

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc[i]),
      .dec   ({1'b0, ret_w[i]} + {1'b0, can_e[i]}),
      .cnt   (cnt[i]),
      .eff   (eff[i])
    );

    assign eff_nz[i]  = (eff[i] != '0);
    assign cnt_max[i] = (cnt[i] == {CNT_W{1'b1}});
  end

  // hazard stall: a source still waiting on an older writer, or the
  // destination counter already full
  always_comb begin
    StallD = (UsesRs1D && A1D != '0 && eff_nz[A1D])
          || (UsesRs2D && A2D != '0 && eff_nz[A2D])
          || (RegWriteD && RdD != '0 && cnt_max[RdD]);
  end

  // debug view of which registers have writes in flight
  always_comb begin
    for (int i = 0; i < NREGS; i++) BusyMask[i] = (cnt[i] != '0);
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Decode-side consumer of the writeback stage. It holds the 32x32 integer register file and receives the writeback triple (register-write enable, destination register, result). It provides two decode read ports with write-before-read bypass. A per-register pending-write scoreboard tracks in-flight destinations from issue to writeback and raises the decode stall on read-after-write hazards.

Parameters:
XLEN, 32, data width of registers and result bus
NREGS, 32, number of architectural registers (x0 hardwired zero)
CNT_W, 2, width of each pending-write counter (max 2^CNT_W-1 in-flight writes per register)

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
A1D  input  5  decode source register 1 address
A2D  input  5  decode source register 2 address
UsesRs1D  input  1  decode instruction reads A1D
UsesRs2D  input  1  decode instruction reads A2D
RD1D  output  XLEN  read data port 1
RD2D  output  XLEN  read data port 2
IssueD  input  1  decode instruction advances to execute this cycle (before stall gating)
RegWriteD  input  1  decode instruction writes a register
RdD  input  5  decode destination register
CancelE  input  1  instruction currently in execute is flushed this cycle
RegWriteE  input  1  execute instruction writes a register
RdE  input  5  execute destination register
RegWriteW  input  1  writeback register-write enable
RdW  input  5  writeback destination register
ResultW  input  XLEN  writeback result
StallD  output  1  decode must hold; issue suppressed
BusyMask  output  NREGS  bit i = counter i nonzero (registered view, debug/verification)

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all counters = 0. Outputs during reset: RD1D/RD2D = 0, StallD = 0, BusyMask = 0. Reset asserted mid-operation discards all pending state immediately.
- Write: at posedge, if RegWriteW && RdW != 0, reg[RdW] <= ResultW. Writes to x0 are ignored.
- Read (combinational, 0-cycle latency):
  - Address 0 -> 0.
  - Else if RegWriteW && RdW == addr -> ResultW (bypass).
  - Else reg[addr].
- Per-register events in one cycle:
  - inc_i = IssueD && !StallD && RegWriteD && RdD == i && i != 0
  - retW_i = RegWriteW && RdW == i && i != 0
  - canE_i = CancelE && RegWriteE && RdE == i && i != 0
- Counter update at posedge: cnt_i <= cnt_i + inc_i - retW_i - canE_i. Simultaneous events net in the same cycle:
  - inc and ret on the same register -> unchanged.
  - ret and cancel on the same register -> minus 2.
- Underflow: the counter clamps at 0 and never wraps. Underflow is a protocol violation that the bench asserts on.
- Effective count: eff_i = cnt_i - retW_i - canE_i, clamped at 0. A value being written back this cycle is supplied by the bypass, so it does not stall.
- StallD is asserted when any of the following holds:
  - UsesRs1D && A1D != 0 && eff[A1D] > 0
  - UsesRs2D && A2D != 0 && eff[A2D] > 0
  - RegWriteD && RdD != 0 && cnt[RdD] == 2^CNT_W-1 (structural saturation guard)
- While StallD = 1, IssueD has no effect on any counter.
- BusyMask[i] = (cnt_i != 0); bit 0 is always 0.
- The counter array is the only sequential state besides the register storage; there is no FSM.

Decomposition:
- Shared package riscv_pkg: XLEN, NREGS, REG_ADDR_W = 5, typedef reg_addr_t (logic [4:0]), typedef xlen_t (logic [XLEN-1:0]).
- Sub-module sb_counter: one saturating up/down counter with inputs inc and dec[1:0], outputs cnt and eff. It is instantiated NREGS-1 times via generate.

Test Plan:
- Reset then read x5 and x0 -> RD1D = 0, RD2D = 0, StallD = 0, BusyMask = 0.
- RegWriteW = 1, RdW = 7, ResultW = 0xDEADBEEF with A1D = 7 in the same cycle -> RD1D = 0xDEADBEEF immediately; next cycle, with no writeback, RD1D = 0xDEADBEEF from storage. Same with RdW = 0 -> read of x0 stays 0.
- Issue writer of x3; next cycle decode reads x3 (UsesRs1D = 1) -> StallD = 1 until the cycle RegWriteW/RdW = 3 arrives. In that cycle StallD = 0 and RD1D = ResultW. BusyMask[3] goes 1 -> 0.
- Issue writer of x4, then CancelE with RegWriteE = 1, RdE = 4 -> cnt[4] returns to 0, StallD for a reader of x4 drops in the cancel cycle.
- Issue writer of x9 in the same cycle RegWriteW retires x9 (cnt = 1) -> cnt stays 1. Three back-to-back issues to x9 with no retire -> fourth decode writing x9 sees StallD = 1.
- Pulse rst_n low mid-stream with BusyMask = 0x0000_0018 -> BusyMask = 0 and storage = 0 asynchronously, without waiting for a clock edge.
